ft601_mcfifo_xfer_sched: RTL and testbench

Round-robin transfer scheduler for the FT601 multi-channel write path. It sits between the per-channel `ft601_mcfifo_wr_buf` instances and the FT601 bus controller, all in the USB read clock domain. It selects one channel whose buffer raises `rd_xfer_req` and drives that channel's `rd_en` while the bus is ready. It holds the grant until the channel signals `rd_xfer_done`, then inserts an inter-packet gap before re-arbitrating.

---
 rtl/ft601_mcfifo_xfer_sched.sv | 149 ++++++++++++++
 tb/tb_ft601_mcfifo_xfer_sched.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft601_mcfifo_xfer_sched.sv
// ft601_mcfifo_xfer_sched
// Round-robin transfer scheduler for the FT601 multi-channel write path.
// It grants one channel buffer at a time and drives that channel's read
// enable while the bus is ready. It holds the grant until the channel reports
// xfer_done, then idles for GAP_CYCLES before it arbitrates again.
//
// Parameters:
//   NUM_CH         number of channel buffers (1, 2 or 4)
//   GAP_CYCLES     idle cycles between transfers (0 skips the gap state)
//   TIMEOUT_CYCLES watchdog limit, only with MCFIFO_XFER_TIMEOUT_EN
// Ports:
//   clk, reset_n   USB read clock, async active-low reset
//   ch_en          per-channel arbitration enable
//   xfer_req       per-channel transfer request from the buffers
//   xfer_done      per-channel end-of-transfer from the buffers
//   rd_valid       per-channel read-data valid, used to count words
//   bus_ready      FT601 controller accepts a word this cycle
//   rd_en          one-hot read enable (combinational from state + inputs)
//   xfer_active    high while in XFER
//   xfer_ch        granted channel index
//   xfer_words     words read in the current or last transfer (saturating)
//   timeout_err    one-cycle pulse after a watchdog abort
// Optional feature: define MCFIFO_XFER_TIMEOUT_EN to build the transfer
// watchdog. Without it, timeout_err is tied low.
module ft601_mcfifo_xfer_sched #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 8192
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] xfer_req,
  input  logic [NUM_CH-1:0] xfer_done,
  input  logic [NUM_CH-1:0] rd_valid,
  input  logic              bus_ready,
  output logic [NUM_CH-1:0] rd_en,
  output logic              xfer_active,
  output logic [1:0]        xfer_ch,
  output logic [12:0]       xfer_words,
  output logic              timeout_err
);

  localparam int unsigned PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned WW = 13;
  localparam logic [WW-1:0] WORDS_MAX = '1;
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, ARB, XFER, GAP} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ch;
  logic [PW-1:0]     grant_idx;
  logic [PW-1:0]     arb_idx;
  logic              grant_found;
  logic [GW-1:0]     gap_cnt;
  logic [NUM_CH-1:0] req_en;
  logic              done_c;
  logic              abort_c;

  assign req_en      = xfer_req & ch_en;
  assign done_c      = xfer_done[ch];
  assign xfer_active = (state == XFER);
  assign xfer_ch     = 2'(ch);

  // Round-robin search from ptr. NUM_CH is a power of two, so truncating the
  // sum to PW bits gives the modulo wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    arb_idx     = ptr;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      arb_idx = ptr + PW'(i);
      if (!grant_found && req_en[arb_idx]) begin
        grant_found = 1'b1;
        grant_idx   = arb_idx;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and read enable
  always_comb begin
    state_nxt = state;
    rd_en     = '0;
    case (state)
      IDLE: if (|req_en) state_nxt = ARB;
      ARB:  state_nxt = grant_found ? XFER : IDLE;
      XFER: begin
        if (bus_ready && !done_c && !abort_c) rd_en[ch] = 1'b1;
        if (done_c || abort_c) state_nxt = (GAP_CYCLES == 0) ? ARB : GAP;
      end
      GAP:  if (gap_cnt == GAP_LAST) state_nxt = ARB;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant capture, rotating pointer, word counter and gap counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr        <= '0;
      ch         <= '0;
      xfer_words <= '0;
      gap_cnt    <= '0;
    end else begin
      if (state == ARB && grant_found) begin
        ch         <= grant_idx;
        xfer_words <= '0;
        ptr        <= (NUM_CH == 1) ? '0 : grant_idx + PW'(1);
      end
      if (state == XFER && rd_valid[ch] && xfer_words != WORDS_MAX)
        xfer_words <= xfer_words + WW'(1);
      gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;
    end
  end

`ifdef MCFIFO_XFER_TIMEOUT_EN
  logic [WW-1:0] wdog;

  // Abort on the TIMEOUT_CYCLES-th XFER cycle; xfer_done takes priority.
  assign abort_c = (state == XFER) && !done_c && (wdog == WW'(TIMEOUT_CYCLES - 1));

  // Watchdog counter and registered error pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog        <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ARB && grant_found) wdog <= '0;
      else if (state == XFER)          wdog <= wdog + WW'(1);
      timeout_err <= abort_c;
    end
  end
`else
  logic unused_tmo;

  assign unused_tmo  = ^WW'(TIMEOUT_CYCLES);
  assign abort_c     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ft601_mcfifo_xfer_sched.sv
`timescale 1ns/1ps
module tb_ft601_mcfifo_xfer_sched;

  localparam int unsigned NCH = 4;
  localparam int unsigned GAPC = 2;
`ifdef MCFIFO_XFER_TIMEOUT_EN
  localparam int unsigned TMO = 64;
`else
  localparam int unsigned TMO = 8192;
`endif

  logic           clk = 1'b0;
  logic           reset_n;
  logic [NCH-1:0] ch_en;
  logic [NCH-1:0] xfer_req;
  logic [NCH-1:0] xfer_done;
  logic [NCH-1:0] rd_valid;
  logic           bus_ready;
  logic [NCH-1:0] rd_en;
  logic           xfer_active;
  logic [1:0]     xfer_ch;
  logic [12:0]    xfer_words;
  logic           timeout_err;

  // Buffer model controls
  logic [7:0]     rem [NCH];
  logic [NCH-1:0] load_mask;
  logic [7:0]     load_len;
  logic           auto_reload;
  logic [NCH-1:0] done_en;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  ft601_mcfifo_xfer_sched #(
    .NUM_CH(NCH), .GAP_CYCLES(GAPC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ch_en(ch_en), .xfer_req(xfer_req),
    .xfer_done(xfer_done), .rd_valid(rd_valid), .bus_ready(bus_ready),
    .rd_en(rd_en), .xfer_active(xfer_active), .xfer_ch(xfer_ch),
    .xfer_words(xfer_words), .timeout_err(timeout_err)
  );

  // Simple buffer model: each read consumes a word, done when empty.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) rem[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (load_mask[c]) rem[c] <= load_len;
        else if (rd_en[c] && rem[c] != 8'd0) rem[c] <= rem[c] - 8'd1;
        else if (auto_reload && rem[c] == 8'd0 && !(xfer_active && xfer_ch == 2'(c)))
          rem[c] <= load_len;
      end
    end
  end

  always_comb begin
    xfer_done = '0;
    for (int c = 0; c < NCH; c++) xfer_done[c] = done_en[c] && (rem[c] == 8'd0);
  end

  assign rd_valid = rd_en;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    ch_en       = 4'hF;
    xfer_req    = '0;
    bus_ready   = 1'b1;
    load_mask   = '0;
    load_len    = '0;
    auto_reload = 1'b0;
    done_en     = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic load(input logic [NCH-1:0] mask, input logic [7:0] len);
    load_mask = mask;
    load_len  = len;
    step();
    load_mask = '0;
  endtask

  task automatic wait_active(input string name);
    int n;
    n = 0;
    while (!xfer_active && n < 20) begin
      step();
      n++;
    end
    chk_cnt++;
    if (!xfer_active) $display("FAIL %s: no grant within 20 cycles", name);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    chk_cnt++; if (rd_en !== 4'b0000) $display("FAIL reset_rd_en: got %b want 0000", rd_en); else pass_cnt++;
    do_reset();
    chk_cnt++; if (xfer_active !== 1'b0) $display("FAIL reset_active: got %b want 0", xfer_active); else pass_cnt++;
    chk_cnt++; if (xfer_ch !== 2'd0) $display("FAIL reset_ch: got %0d want 0", xfer_ch); else pass_cnt++;
    chk_cnt++; if (xfer_words !== 13'd0) $display("FAIL reset_words: got %0d want 0", xfer_words); else pass_cnt++;
    chk_cnt++; if (timeout_err !== 1'b0) $display("FAIL reset_tmo: got %b want 0", timeout_err); else pass_cnt++;
  endtask

  task automatic test_single();
    int n;
    int other;
    do_reset();
    load(4'b0100, 8'd16);
    xfer_req = 4'b0100;
    step();
    chk_cnt++; if (rd_en !== 4'b0000 || xfer_active !== 1'b0)
      $display("FAIL single_arb: rd_en %b active %b want 0000/0", rd_en, xfer_active); else pass_cnt++;
    step();
    chk_cnt++; if (rd_en !== 4'b0100) $display("FAIL single_first_rd: got %b want 0100", rd_en); else pass_cnt++;
    chk_cnt++; if (xfer_ch !== 2'd2) $display("FAIL single_ch: got %0d want 2", xfer_ch); else pass_cnt++;
    xfer_req = '0;
    n = 0;
    other = 0;
    for (int i = 0; i < 40; i++) begin
      if (rd_en == 4'b0100) n++;
      if ((rd_en & 4'b1011) != 4'b0000) other++;
      if (!xfer_active) break;
      step();
    end
    chk_cnt++; if (n != 16 || other != 0) $display("FAIL single_rd_cycles: got %0d (stray %0d) want 16", n, other); else pass_cnt++;
    chk_cnt++; if (xfer_words !== 13'd16) $display("FAIL single_words: got %0d want 16", xfer_words); else pass_cnt++;
    step();
    chk_cnt++; if (xfer_active !== 1'b0 || rd_en !== 4'b0000 || xfer_words !== 13'd16)
      $display("FAIL single_gap: active %b rd_en %b words %0d want 0/0000/16", xfer_active, rd_en, xfer_words); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int grants [5];
    int exp_g [5];
    int ng;
    int idle_run;
    int gap_bad;
    int stray;
    logic prev;
    exp_g = '{0, 1, 2, 3, 0};
    do_reset();
    auto_reload = 1'b1;
    load(4'hF, 8'd4);
    xfer_req = 4'hF;
    ng = 0; idle_run = 0; gap_bad = 0; stray = 0; prev = 1'b0;
    for (int i = 0; i < 200 && ng < 5; i++) begin
      step();
      if (xfer_active && !prev) begin
        if (ng > 0 && idle_run != int'(GAPC) + 1) gap_bad++;
        grants[ng] = int'(xfer_ch);
        ng++;
      end
      if (!xfer_active) idle_run++;
      else idle_run = 0;
      if (!xfer_active && rd_en != 4'b0000) stray++;
      prev = xfer_active;
    end
    chk_cnt++; if (ng != 5) $display("FAIL rr_count: got %0d grants want 5", ng); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      chk_cnt++;
      if (k >= ng || grants[k] != exp_g[k]) $display("FAIL rr_order[%0d]: got %0d want %0d", k, (k < ng) ? grants[k] : -1, exp_g[k]);
      else pass_cnt++;
    end
    chk_cnt++; if (gap_bad != 0 || stray != 0) $display("FAIL rr_gap: bad gaps %0d stray rd_en %0d want 0/0", gap_bad, stray); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int bad;
    do_reset();
    load(4'b0010, 8'd16);
    xfer_req = 4'b0010;
    wait_active("bp_grant");
    xfer_req = '0;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      bus_ready = (i % 2 == 0);
      #1;
      if (rd_en !== (bus_ready ? 4'b0010 : 4'b0000)) bad++;
      step();
    end
    bus_ready = 1'b1;
    chk_cnt++; if (bad != 0) $display("FAIL bp_follow: %0d cycles rd_en differs from bus_ready", bad); else pass_cnt++;
    chk_cnt++; if (xfer_words !== 13'd16) $display("FAIL bp_words: got %0d want 16", xfer_words); else pass_cnt++;
    chk_cnt++; if (xfer_active !== 1'b0) $display("FAIL bp_exit: active %b want 0", xfer_active); else pass_cnt++;
  endtask

  task automatic test_masking();
    int grants [4];
    int exp_g [4];
    int ng;
    int n0;
    logic prev;
    exp_g = '{1, 3, 1, 3};
    do_reset();
    ch_en = 4'b1011;
    auto_reload = 1'b1;
    load(4'hF, 8'd4);
    xfer_req = 4'hF;
    wait_active("mask_grant");
    chk_cnt++; if (xfer_ch !== 2'd0) $display("FAIL mask_first: got %0d want 0", xfer_ch); else pass_cnt++;
    ch_en = 4'b1010;
    n0 = 0;
    for (int i = 0; i < 20; i++) begin
      if (rd_en[0]) n0++;
      if (!xfer_active) break;
      step();
    end
    chk_cnt++; if (n0 != 4 || xfer_words !== 13'd4)
      $display("FAIL mask_complete: reads %0d words %0d want 4/4", n0, xfer_words); else pass_cnt++;
    ng = 0; prev = xfer_active;
    for (int i = 0; i < 200 && ng < 4; i++) begin
      step();
      if (xfer_active && !prev) begin
        grants[ng] = int'(xfer_ch);
        ng++;
      end
      prev = xfer_active;
    end
    for (int k = 0; k < 4; k++) begin
      chk_cnt++;
      if (k >= ng || grants[k] != exp_g[k]) $display("FAIL mask_order[%0d]: got %0d want %0d", k, (k < ng) ? grants[k] : -1, exp_g[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    load(4'b1000, 8'd16);
    xfer_req = 4'b1000;
    n = 0;
    while (rd_en != 4'b1000 && n < 20) begin
      step();
      n++;
    end
    chk_cnt++; if (rd_en !== 4'b1000) $display("FAIL rst_mid_setup: rd_en %b want 1000", rd_en); else pass_cnt++;
    #1;
    reset_n = 1'b0;
    #1;
    chk_cnt++; if (rd_en !== 4'b0000 || xfer_active !== 1'b0)
      $display("FAIL rst_mid_async: rd_en %b active %b want 0000/0", rd_en, xfer_active); else pass_cnt++;
    chk_cnt++; if (xfer_words !== 13'd0) $display("FAIL rst_mid_words: got %0d want 0", xfer_words); else pass_cnt++;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    load(4'b1001, 8'd8);
    xfer_req = 4'b1001;
    wait_active("rst_mid_regrant");
    chk_cnt++; if (xfer_ch !== 2'd0) $display("FAIL rst_mid_first: got %0d want 0", xfer_ch); else pass_cnt++;
  endtask

`ifdef MCFIFO_XFER_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    int nrd;
    int early;
    do_reset();
    done_en = 4'b1101;
    load(4'b0010, 8'd200);
    load(4'b0100, 8'd4);
    xfer_req = 4'b0110;
    wait_active("tmo_grant");
    chk_cnt++; if (xfer_ch !== 2'd1) $display("FAIL tmo_ch: got %0d want 1", xfer_ch); else pass_cnt++;
    xfer_req = 4'b0100;
    cyc = 0; nrd = 0; early = 0;
    for (int i = 0; i < 100; i++) begin
      if (!xfer_active) break;
      cyc++;
      if (rd_en[1]) nrd++;
      if (timeout_err) early++;
      step();
    end
    chk_cnt++; if (cyc != 64 || nrd != 63 || early != 0)
      $display("FAIL tmo_len: xfer cycles %0d reads %0d early err %0d want 64/63/0", cyc, nrd, early); else pass_cnt++;
    chk_cnt++; if (timeout_err !== 1'b1) $display("FAIL tmo_pulse: got %b want 1", timeout_err); else pass_cnt++;
    step();
    chk_cnt++; if (timeout_err !== 1'b0 || xfer_active !== 1'b0)
      $display("FAIL tmo_pulse_end: err %b active %b want 0/0", timeout_err, xfer_active); else pass_cnt++;
    wait_active("tmo_next");
    chk_cnt++; if (xfer_ch !== 2'd2) $display("FAIL tmo_next_ch: got %0d want 2", xfer_ch); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_masking();
    test_reset_mid();
`ifdef MCFIFO_XFER_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
